mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle RV64M multiply/divide unit and its sequencer.
- Sits beside the execute-stage ALU. Accepts one op per request and holds the pipeline through ok_to_proceed until the result is ready.
- Divide and remainder use a radix-2 restoring iteration. Multiply uses a registered product with a fixed latency count.
- Returns a 64-bit result, sign-extended for word ops, to the execute stage result mux.

Parameters:
- XLEN, 64, datapath width.
- MUL_CYCLES, 2, multiply cycles after acceptance before DONE (range 1..8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  execute stage holds a valid M-extension op
- req_op  in  3  mdu_op_t
- req_word  in  1  RV64 *W variant
- req_a  in  64  operand A (rs1)
- req_b  in  64  operand B (rs2)
- flush  in  1  abort current op (branch/exception)
- ok_to_proceed_overall  in  1  global pipeline advance
- ok_to_proceed  out  1  this unit allows pipeline advance
- busy  out  1  state is not IDLE
- resp_valid  out  1  result valid (DONE state)
- resp_data  out  64  result

Behaviour:
- Reset is one clk edge with rst=1. State goes to IDLE. resp_valid=0, resp_data=0, busy=0, counters=0. ok_to_proceed then equals !req_valid.
- States: IDLE, MUL_RUN, DIV_RUN, FIXUP, DONE.
- IDLE, req_valid=1, flush=0: latch operands, op and word.
  - Word ops: operands are sign-extended from bit 31 for signed ops and zero-extended for unsigned ops.
  - MUL*: go to MUL_RUN, cnt=MUL_CYCLES-1.
  - Divide by zero: go to DONE. Quotient=all ones, remainder=dividend, word-extended.
  - Signed overflow (MIN/-1 at the active width): go to DONE. Quotient=MIN, remainder=0.
  - All other DIV*/REM*: go to DIV_RUN. Divide on magnitudes, cnt = 63 (or 31 for word).
- MUL_RUN: decrement cnt. At cnt=0, go to DONE with the selected half of the 128-bit product.
  - MUL and MULW take the low half (MULW sign-extends bit 31).
  - MULH, MULHSU and MULHU take the high half with their signedness.
  - req_word with MULH* is ignored (full width).
- DIV_RUN: one quotient bit per cycle, MSB first. rem = {rem,dividend_bit} minus divisor when ≥ divisor. At cnt=0, go to FIXUP.
- FIXUP: one cycle. Negate the quotient if the operand signs differ (signed ops). Negate the remainder if the dividend is negative. Apply word sign-extension. Go to DONE.
- DONE: resp_valid=1 and resp_data is stable. Stay until ok_to_proceed_overall=1, then go to IDLE next cycle.
- ok_to_proceed is combinational: 1 in DONE, 1 in IDLE with req_valid=0, 0 otherwise.
- Latency, request accepted at cycle T:
  - 64-bit DIV: resp_valid at T+66.
  - Word DIV: T+34.
  - MUL: T+MUL_CYCLES+1.
  - Special cases: T+1.
- Flush, in any state: IDLE next cycle, resp_valid=0, no response produced. Flush has priority over acceptance and over DONE exit.
- rst mid-operation: same effect as flush; all registers cleared.
- resp_data is held between DONE exit and the next DONE.

Optional Feature:
- MDU_DIV_EARLY_OUT_EN, when defined: in IDLE, an unsigned or magnitude compare with |dividend| < |divisor| (divisor nonzero) goes directly to FIXUP. Quotient=0, remainder=dividend. Latency T+2.
- When undefined: these ops take the full iteration count. Results are identical either way.

Decomposition:
- Shared package (common) holds:
  - mdu_op_t enum: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - mdu_state_t.
  - MDU_DIV_ITERS_D=64 and MDU_DIV_ITERS_W=32.
- One natural sub-module, mdu_div_step: combinational single restoring-divide step (rem, divisor, next bit) → (next rem, quotient bit). The FSM and counters stay in mdu_sequencer.

Test Plan:
- DIV a=-7, b=2, then REM with the same operands → resp 0xFFFFFFFFFFFFFFFD at T+66, then 0xFFFFFFFFFFFFFFFF. ok_to_proceed=0 from T to T+65.
- DIVU a=0x1234, b=0 → T+1 resp 0xFFFFFFFFFFFFFFFF. REMU with the same operands → 0x1234.
- DIV a=0x8000000000000000, b=-1 → 0x8000000000000000 at T+1. DIVW a=0x0000000180000000, b=-1 → 0xFFFFFFFF80000000.
- MULHU a=b=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE at T+3. MULW a=0x7FFFFFFF, b=2 → 0xFFFFFFFFFFFFFFFE.
- DIV 100/7 with flush at T+10 → IDLE at T+11, resp_valid never asserted. Next request is accepted normally.
- DONE with ok_to_proceed_overall held 0 for 5 cycles → resp_valid and resp_data stable for those cycles, IDLE one cycle after it rises.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// Shared types and constants for the RV64M multiply/divide unit.
// Used by mdu_sequencer and mdu_div_step.
package mdu_sequencer_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_RUN = 3'd1,
    DIV_RUN = 3'd2,
    FIXUP   = 3'd3,
    DONE    = 3'd4
  } mdu_state_t;

  localparam int MDU_DIV_ITERS_D = 64;
  localparam int MDU_DIV_ITERS_W = 32;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring divide step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] divisor,
  input  logic         next_bit,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0]   trial;
  logic [W-1:0] diff;

  // rem < divisor on entry, so a fitting difference always fits in W bits
  assign trial    = {rem, next_bit};
  assign diff     = trial[W-1:0] - divisor;
  assign q_bit    = (trial >= {1'b0, divisor});
  assign rem_next = q_bit ? diff : trial[W-1:0];

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV64M multiply/divide unit with its pipeline-hold sequencer.
// Optional macro MDU_DIV_EARLY_OUT_EN: skip the iteration when |dividend| < |divisor|.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  mdu_op_t         req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  input  logic            ok_to_proceed_overall,
  output logic            ok_to_proceed,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data
);

  mdu_state_t      state_q, state_d;
  mdu_op_t         op_q;
  logic            word_q, neg_q_q, neg_r_q;
  logic [XLEN-1:0] a_q, b_q, quo_q, rem_q, result_q, result_d;
  logic [5:0]      cnt_q;

  logic            is_mul, eff_word, div_signed, sgn_ext, is_rem;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
  logic            a_neg, b_neg, div_zero, div_ovf, early_out, accept;

  // MULH* ignore the word flag; word operands extend by the op's signedness
  assign is_mul     = !req_op[2];
  assign eff_word   = req_word && (req_op[2] || (req_op == MUL));
  assign div_signed = (req_op == DIV) || (req_op == REM);
  assign sgn_ext    = div_signed || (req_op == MUL);
  assign is_rem     = req_op[1];
  assign a_ext      = !eff_word ? req_a : (sgn_ext ? sext32(req_a[31:0]) : {32'b0, req_a[31:0]});
  assign b_ext      = !eff_word ? req_b : (sgn_ext ? sext32(req_b[31:0]) : {32'b0, req_b[31:0]});
  assign a_neg      = div_signed && a_ext[XLEN-1];
  assign b_neg      = div_signed && b_ext[XLEN-1];
  assign a_mag      = a_neg ? -a_ext : a_ext;
  assign b_mag      = b_neg ? -b_ext : b_ext;
  assign min_val    = eff_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign div_zero   = (b_ext == '0);
  assign div_ovf    = div_signed && (a_ext == min_val) && (b_ext == '1);
  assign accept     = (state_q == IDLE) && req_valid && !flush;

`ifdef MDU_DIV_EARLY_OUT_EN
  assign early_out = (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  logic            a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_wide, b_wide, prod;
  logic [XLEN-1:0] mul_res;

  assign a_sgn   = (op_q != MULHU) && a_q[XLEN-1];
  assign b_sgn   = ((op_q == MUL) || (op_q == MULH)) && b_q[XLEN-1];
  assign a_wide  = {{XLEN{a_sgn}}, a_q};
  assign b_wide  = {{XLEN{b_sgn}}, b_q};
  assign prod    = a_wide * b_wide;
  assign mul_res = (op_q == MUL) ? (word_q ? sext32(prod[31:0]) : prod[XLEN-1:0])
                                 : prod[2*XLEN-1:XLEN];

  logic [XLEN-1:0] q_fix, r_fix, fix_sel, fix_res, step_rem;
  logic            step_qbit;

  assign q_fix   = neg_q_q ? -quo_q : quo_q;
  assign r_fix   = neg_r_q ? -rem_q : rem_q;
  assign fix_sel = op_q[1] ? r_fix : q_fix;
  assign fix_res = word_q ? sext32(fix_sel[31:0]) : fix_sel;

  mdu_div_step #(.W(XLEN)) u_div_step (
    .rem      (rem_q),
    .divisor  (b_q),
    .next_bit (quo_q[XLEN-1]),
    .rem_next (step_rem),
    .q_bit    (step_qbit)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (is_mul) begin
            state_d = MUL_RUN;
          end else if (div_zero) begin
            state_d  = DONE;
            result_d = is_rem ? (eff_word ? sext32(a_ext[31:0]) : a_ext) : '1;
          end else if (div_ovf) begin
            state_d  = DONE;
            result_d = is_rem ? '0 : a_ext;
          end else if (early_out) begin
            state_d = FIXUP;
          end else begin
            state_d = DIV_RUN;
          end
        end
      end
      MUL_RUN: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = mul_res;
        end
      end
      DIV_RUN: if (cnt_q == '0) state_d = FIXUP;
      FIXUP: begin
        state_d  = DONE;
        result_d = fix_res;
      end
      DONE:    if (ok_to_proceed_overall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // flush wins over acceptance, completion and DONE exit; result is not touched
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= MUL;
      word_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            word_q  <= eff_word;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            if (is_mul) begin
              a_q   <= a_ext;
              b_q   <= b_ext;
              cnt_q <= 6'(MUL_CYCLES - 1);
            end else begin
              a_q   <= a_ext;
              b_q   <= b_mag;
              cnt_q <= eff_word ? 6'(MDU_DIV_ITERS_W - 1) : 6'(MDU_DIV_ITERS_D - 1);
              if (early_out) begin
                quo_q <= '0;
                rem_q <= a_mag;
              end else begin
                // word dividends are pre-shifted so the MSB-first walk starts at bit 31
                quo_q <= eff_word ? {a_mag[31:0], 32'b0} : a_mag;
                rem_q <= '0;
              end
            end
          end
        end
        MUL_RUN: cnt_q <= cnt_q - 6'd1;
        DIV_RUN: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[XLEN-2:0], step_qbit};
          cnt_q <= cnt_q - 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign resp_valid    = (state_q == DONE);
  assign resp_data     = result_q;
  assign ok_to_proceed = (state_q == DONE) || ((state_q == IDLE) && !req_valid);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized and directed bench for mdu_sequencer against an arithmetic
// reference model of RV64M results and latencies.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  mdu_op_t     req_op;
  logic        req_word;
  logic [63:0] req_a, req_b;
  logic        flush;
  logic        ok_to_proceed_overall;
  logic        ok_to_proceed, busy, resp_valid;
  logic [63:0] resp_data;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_data;

  mdu_sequencer #(.XLEN(64), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_valid             (req_valid),
    .req_op                (req_op),
    .req_word              (req_word),
    .req_a                 (req_a),
    .req_b                 (req_b),
    .flush                 (flush),
    .ok_to_proceed_overall (ok_to_proceed_overall),
    .ok_to_proceed         (ok_to_proceed),
    .busy                  (busy),
    .resp_valid            (resp_valid),
    .resp_data             (resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] r);
    return {{32{r[31]}}, r};
  endfunction

  // RV64M result as defined by the ISA, from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic word,
                                              input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    int           wa, wb;
    int unsigned  ua, ub;
    longint       sa, sb;
    logic [31:0]  r;
    wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0]; sa = a; sb = b;
    case (op)
      3'd0: begin
        if (word) begin
          r = a[31:0] * b[31:0];
          return sx(r);
        end
        return a * b;
      end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b};       return p[127:64]; end
      3'd3: begin p = {64'b0, a} * {64'b0, b};             return p[127:64]; end
      3'd4: begin
        if (word) begin
          if (wb == 0) r = '1;
          else if (a[31:0] == 32'h8000_0000 && wb == -1) r = a[31:0];
          else r = wa / wb;
          return sx(r);
        end
        if (sb == 0) return '1;
        if (a == 64'h8000_0000_0000_0000 && sb == -1) return a;
        return sa / sb;
      end
      3'd5: begin
        if (word) begin
          r = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
          return sx(r);
        end
        return (b == 0) ? '1 : a / b;
      end
      3'd6: begin
        if (word) begin
          if (wb == 0) r = a[31:0];
          else if (a[31:0] == 32'h8000_0000 && wb == -1) r = '0;
          else r = wa % wb;
          return sx(r);
        end
        if (sb == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && sb == -1) return '0;
        return sa % sb;
      end
      default: begin
        if (word) begin
          r = (ub == 0) ? a[31:0] : ua % ub;
          return sx(r);
        end
        return (b == 0) ? a : a % b;
      end
    endcase
  endfunction

  // cycles from the request cycle to the first resp_valid cycle
  function automatic int exp_lat(input logic [2:0] op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
    logic                sgn;
    int                  wa, wb;
    longint              sa, sb;
    longint unsigned     ma, mb;
    if (op < 3'd4) return MUL_CYCLES + 1;
    sgn = (op == 3'd4) || (op == 3'd6);
    if (word) begin
      wa = a[31:0]; wb = b[31:0];
      sa = sgn ? longint'(wa) : longint'({32'b0, a[31:0]});
      sb = sgn ? longint'(wb) : longint'({32'b0, b[31:0]});
      if (sb == 0) return 1;
      if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
    end else begin
      sa = a; sb = b;
      if (sb == 0) return 1;
      if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    end
    ma = (sgn && sa < 0) ? longint'(-sa) : sa;
    mb = (sgn && sb < 0) ? longint'(-sb) : sb;
`ifdef MDU_DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`else
    if (ma < mb && mb == 0) return 0;
`endif
    return word ? 34 : 66;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input int hold);
    int          cyc, err;
    logic [63:0] exp;
    exp_q.push_back(ref_result(op, word, a, b));
    @(negedge clk);
    req_valid = 1'b1; req_op = mdu_op_t'(op); req_word = word; req_a = a; req_b = b;
    #1 check("okp_req", ok_to_proceed, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; err = 0;
    while (!resp_valid && cyc < 200) begin
      if (ok_to_proceed !== 1'b0 || busy !== 1'b1) err++;
      @(negedge clk);
      cyc++;
    end
    check("stall", err, 0);
    check("latency", cyc, exp_lat(op, word, a, b));
    exp = exp_q.pop_front();
    check("data", resp_data, exp);
    check("okp_done", ok_to_proceed, 1);
    err = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== exp) err++;
    end
    if (hold > 0) check("hold", err, 0);
    ok_to_proceed_overall = 1'b1;
    @(negedge clk);
    ok_to_proceed_overall = 1'b0;
    check("exit", {busy, resp_valid}, 0);
    check("held", resp_data, exp);
    last_data = exp;
  endtask

  function automatic logic [63:0] rnd_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0, 1:    v = {$urandom, $urandom};
      2:       v = 64'($urandom_range(0, 20));
      3:       v = '0;
      4:       v = '1;
      5:       v = 64'h8000_0000_0000_0000;
      6:       v = {$urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0, $urandom};
      default: v = -64'($urandom_range(1, 20));
    endcase
    return v;
  endfunction

  initial begin
    int          cyc, err;
    logic [63:0] tmp;
    rst = 1'b1; req_valid = 1'b0; req_op = MUL; req_word = 1'b0;
    req_a = '0; req_b = '0; flush = 1'b0; ok_to_proceed_overall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_data", resp_data, 0);
    check("rst_okp_idle", ok_to_proceed, 1);
    req_valid = 1'b1;
    #1 check("rst_okp_req", ok_to_proceed, 0);
    req_valid = 1'b0;
    last_data = '0;

    // directed cases
    run_op(3'd4, 1'b0, -64'sd7, 64'sd2, 0);
    run_op(3'd6, 1'b0, -64'sd7, 64'sd2, 0);
    run_op(3'd5, 1'b0, 64'h1234, 64'h0, 0);
    run_op(3'd7, 1'b0, 64'h1234, 64'h0, 0);
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
    run_op(3'd4, 1'b1, 64'h0000_0001_8000_0000, '1, 0);
    run_op(3'd3, 1'b0, '1, '1, 0);
    run_op(3'd0, 1'b1, 64'h7FFF_FFFF, 64'h2, 5);
    run_op(3'd5, 1'b1, 64'hFFFF_FFFF, 64'h1, 0);
    run_op(3'd6, 1'b1, 64'h8000_0000, 64'h3, 1);

    // flush at T+10 during a divide
    @(negedge clk);
    req_valid = 1'b1; req_op = DIV; req_word = 1'b0; req_a = 64'd100; req_b = 64'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; err = 0;
    while (cyc < 10) begin
      if (resp_valid) err++;
      @(negedge clk);
      cyc++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", busy, 0);
    check("flush_valid", resp_valid, 0);
    check("flush_data", resp_data, last_data);
    check("flush_early", err, 0);
    run_op(3'd4, 1'b0, 64'd100, 64'd7, 0);

    // flush beats acceptance
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = MULHU; req_a = '1; req_b = '1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_accept", busy, 0);

    // flush in DONE with the pipeline held
    @(negedge clk);
    req_valid = 1'b1; req_op = MULHU; req_word = 1'b0; req_a = '1; req_b = '1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done_reached", resp_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done", {busy, resp_valid}, 0);
    last_data = 64'hFFFF_FFFF_FFFF_FFFE;

    // reset mid-divide clears everything
    @(negedge clk);
    req_valid = 1'b1; req_op = DIVU; req_word = 1'b0; req_a = 64'd999; req_b = 64'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data", resp_data, 0);
    run_op(3'd5, 1'b0, 64'd999, 64'd3, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      tmp = rnd_operand();
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), tmp, rnd_operand(),
             $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
